// File: rtl/pattern_logger_pkg.sv
// Shared defaults and helpers for the pattern event logger and its FIFO.
package pattern_logger_pkg;

  localparam int TS_WIDTH_DEF   = 16;
  localparam int CNT_WIDTH_DEF  = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with occupancy level and synchronous clear.
module sync_fifo_fwft
  import pattern_logger_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  input  logic                    clear_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        din_i,
  output logic [WIDTH-1:0]        dout_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [clog2(DEPTH):0]   level_o
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
      else if (pop_ok && !push_ok) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/pattern_event_logger.sv
// Timestamps detector pulses into a FWFT FIFO; keeps a saturating event count and sticky overflow.
module pattern_event_logger
  import pattern_logger_pkg::*;
#(
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic                        i_enable,
  input  logic                        i_clear,
  input  logic                        i_pattern_found,
  output logic                        o_ts_valid,
  output logic [TS_WIDTH-1:0]         o_ts_data,
  input  logic                        i_ts_ready,
  output logic [CNT_WIDTH-1:0]        o_event_count,
  output logic [clog2(FIFO_DEPTH):0]  o_fifo_level,
  output logic                        o_overflow
);

  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 event_hit, pop, drop, fifo_full, fifo_empty;

  assign event_hit = i_pattern_found & i_enable;
  assign pop       = o_ts_valid & i_ts_ready;
  assign drop      = event_hit & fifo_full & ~pop;

  sync_fifo_fwft #(
    .WIDTH (TS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .clear_i  (i_clear),
    .push_i   (event_hit & ~i_clear),
    .pop_i    (pop & ~i_clear),
    .din_i    (ts_q),
    .dout_o   (o_ts_data),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .level_o  (o_fifo_level)
  );

  assign o_ts_valid    = ~fifo_empty;
  assign o_event_count = cnt_q;
  assign o_overflow    = ovf_q;

  always_comb begin
    ts_d  = ts_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (i_clear) begin
      ts_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (i_enable) ts_d = ts_q + TS_WIDTH'(1);
      if (event_hit && cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      ts_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ts_q  <= ts_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pattern_event_logger.sv
// Directed self-checking bench for pattern_event_logger (default and 3-bit counter instances).
module tb_pattern_event_logger;

  logic        clk, rstn, en, clr, pf, rdy;
  logic        valid, ovf, valid2, ovf2;
  logic [15:0] data, data2;
  logic [7:0]  cnt;
  logic [2:0]  cnt2;
  logic [2:0]  lvl, lvl2;
  int          pass_cnt, total_cnt;

  pattern_event_logger dut (
    .i_clk(clk), .i_resetn(rstn), .i_enable(en), .i_clear(clr),
    .i_pattern_found(pf), .o_ts_valid(valid), .o_ts_data(data),
    .i_ts_ready(rdy), .o_event_count(cnt), .o_fifo_level(lvl),
    .o_overflow(ovf)
  );

  pattern_event_logger #(.CNT_WIDTH(3)) dut_sat (
    .i_clk(clk), .i_resetn(rstn), .i_enable(en), .i_clear(clr),
    .i_pattern_found(pf), .o_ts_valid(valid2), .o_ts_data(data2),
    .i_ts_ready(rdy), .o_event_count(cnt2), .o_fifo_level(lvl2),
    .o_overflow(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; clr = 1'b0; pf = 1'b0; rdy = 1'b0;
    #12;
    total_cnt++; if (valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", valid); else pass_cnt++;
    total_cnt++; if (data !== 16'd0) $display("FAIL rst_data: got %0d want 0", data); else pass_cnt++;
    total_cnt++; if (cnt !== 8'd0) $display("FAIL rst_count: got %0d want 0", cnt); else pass_cnt++;
    total_cnt++; if (lvl !== 3'd0) $display("FAIL rst_level: got %0d want 0", lvl); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL rst_overflow: got %0b want 0", ovf); else pass_cnt++;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_single();
    en = 1'b1;
    repeat (10) tick();
    pf = 1'b1;
    tick();
    pf = 1'b0;
    total_cnt++; if (valid !== 1'b1) $display("FAIL single_valid: got %0b want 1", valid); else pass_cnt++;
    total_cnt++; if (data !== 16'd10) $display("FAIL single_data: got %0d want 10", data); else pass_cnt++;
    total_cnt++; if (cnt !== 8'd1) $display("FAIL single_count: got %0d want 1", cnt); else pass_cnt++;
    total_cnt++; if (lvl !== 3'd1) $display("FAIL single_level: got %0d want 1", lvl); else pass_cnt++;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL single_pop_valid: got %0b want 0", valid); else pass_cnt++;
    total_cnt++; if (lvl !== 3'd0) $display("FAIL single_pop_level: got %0d want 0", lvl); else pass_cnt++;
    total_cnt++; if (data !== 16'd0) $display("FAIL single_pop_data: got %0d want 0", data); else pass_cnt++;
  endtask

  // Bench-side 101001 detector feeds the logger; matches land on ts 5 and 10.
  task automatic test_detector_stream();
    logic [10:0] bits;
    logic [5:0]  hist;
    bits = 11'b1_0100_1010_01;
    hist = '0;
    do_clear();
    for (int i = 0; i < 11; i++) begin
      hist = {hist[4:0], bits[10-i]};
      pf = (hist == 6'b101001);
      tick();
    end
    pf = 1'b0;
    total_cnt++; if (lvl !== 3'd2) $display("FAIL stream_level: got %0d want 2", lvl); else pass_cnt++;
    total_cnt++; if (cnt !== 8'd2) $display("FAIL stream_count: got %0d want 2", cnt); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL stream_overflow: got %0b want 0", ovf); else pass_cnt++;
    total_cnt++; if (data !== 16'd5) $display("FAIL stream_first: got %0d want 5", data); else pass_cnt++;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    total_cnt++; if (data !== 16'd10) $display("FAIL stream_second: got %0d want 10", data); else pass_cnt++;
    total_cnt++; if (lvl !== 3'd1) $display("FAIL stream_level_after_pop: got %0d want 1", lvl); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_clear();
    pf = 1'b1;
    repeat (6) tick();
    pf = 1'b0;
    total_cnt++; if (lvl !== 3'd4) $display("FAIL ovf_level: got %0d want 4", lvl); else pass_cnt++;
    total_cnt++; if (cnt !== 8'd6) $display("FAIL ovf_count: got %0d want 6", cnt); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", ovf); else pass_cnt++;
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (data !== 16'(k)) $display("FAIL ovf_order[%0d]: got %0d want %0d", k, data, k); else pass_cnt++;
      tick();
    end
    rdy = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL ovf_drained_valid: got %0b want 0", valid); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", ovf); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_seq [4];
    exp_seq = '{16'd1, 16'd2, 16'd3, 16'd4};
    do_clear();
    pf = 1'b1;
    repeat (4) tick();
    rdy = 1'b1;
    tick();
    pf = 1'b0;
    rdy = 1'b0;
    total_cnt++; if (lvl !== 3'd4) $display("FAIL fullpp_level: got %0d want 4", lvl); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL fullpp_overflow: got %0b want 0", ovf); else pass_cnt++;
    total_cnt++; if (cnt !== 8'd5) $display("FAIL fullpp_count: got %0d want 5", cnt); else pass_cnt++;
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (data !== exp_seq[k]) $display("FAIL fullpp_order[%0d]: got %0d want %0d", k, data, exp_seq[k]); else pass_cnt++;
      tick();
    end
    rdy = 1'b0;
    total_cnt++; if (lvl !== 3'd0) $display("FAIL fullpp_drained: got %0d want 0", lvl); else pass_cnt++;
  endtask

  task automatic test_saturate_clear();
    do_clear();
    rdy = 1'b1;
    pf = 1'b1;
    repeat (9) tick();
    pf = 1'b0;
    total_cnt++; if (cnt2 !== 3'd7) $display("FAIL sat_count3: got %0d want 7", cnt2); else pass_cnt++;
    total_cnt++; if (cnt !== 8'd9) $display("FAIL sat_count8: got %0d want 9", cnt); else pass_cnt++;
    total_cnt++; if (ovf2 !== 1'b0) $display("FAIL sat_overflow: got %0b want 0", ovf2); else pass_cnt++;
    clr = 1'b1;
    pf = 1'b1;
    tick();
    clr = 1'b0;
    pf = 1'b0;
    rdy = 1'b0;
    total_cnt++; if (cnt !== 8'd0) $display("FAIL clr_count: got %0d want 0", cnt); else pass_cnt++;
    total_cnt++; if (cnt2 !== 3'd0) $display("FAIL clr_count3: got %0d want 0", cnt2); else pass_cnt++;
    total_cnt++; if (lvl !== 3'd0) $display("FAIL clr_level: got %0d want 0", lvl); else pass_cnt++;
    total_cnt++; if (valid !== 1'b0) $display("FAIL clr_valid: got %0b want 0", valid); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL clr_overflow: got %0b want 0", ovf); else pass_cnt++;
  endtask

  task automatic test_enable_and_reset();
    en = 1'b0;
    pf = 1'b1;
    repeat (5) tick();
    pf = 1'b0;
    total_cnt++; if (lvl !== 3'd0) $display("FAIL dis_level: got %0d want 0", lvl); else pass_cnt++;
    total_cnt++; if (cnt !== 8'd0) $display("FAIL dis_count: got %0d want 0", cnt); else pass_cnt++;
    en = 1'b1;
    pf = 1'b1;
    tick();
    pf = 1'b0;
    total_cnt++; if (data !== 16'd0) $display("FAIL dis_frozen_ts: got %0d want 0", data); else pass_cnt++;
    total_cnt++; if (valid !== 1'b1) $display("FAIL dis_then_valid: got %0b want 1", valid); else pass_cnt++;
    rstn = 1'b0;
    #2;
    total_cnt++; if (valid !== 1'b0) $display("FAIL arst_valid: got %0b want 0", valid); else pass_cnt++;
    total_cnt++; if (lvl !== 3'd0) $display("FAIL arst_level: got %0d want 0", lvl); else pass_cnt++;
    total_cnt++; if (cnt !== 8'd0) $display("FAIL arst_count: got %0d want 0", cnt); else pass_cnt++;
    total_cnt++; if (data !== 16'd0) $display("FAIL arst_data: got %0d want 0", data); else pass_cnt++;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_detector_stream();
    test_overflow();
    test_full_push_pop();
    test_saturate_clear();
    test_enable_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pattern_event_logger.md
Name: pattern_event_logger

Overview:
- Sits directly downstream of the 101001 sequence detector and consumes its one-cycle o_pattern_found pulse.
- Timestamps every detection with a free-running cycle counter and buffers the timestamps in a small first-word-fall-through FIFO.
- Drains the FIFO over a valid/ready interface.
- Keeps a saturating total-detection count and a sticky overflow flag for status readback.

Parameters:
TS_WIDTH, 16, width of timestamp counter and of each FIFO entry
CNT_WIDTH, 8, width of saturating detection counter
FIFO_DEPTH, 4, number of FIFO entries; power of 2, >= 2

Ports:
i_clk  in  1  single clock, rising edge
i_resetn  in  1  asynchronous active-low reset
i_enable  in  1  1 = timestamp counter runs and events are accepted
i_clear  in  1  synchronous clear of FIFO, counters and flags
i_pattern_found  in  1  detection pulse from sequence detector; each high cycle is one event
o_ts_valid  out  1  FIFO head holds a timestamp
o_ts_data  out  TS_WIDTH  timestamp at FIFO head
i_ts_ready  in  1  consumer accepts head when o_ts_valid=1
o_event_count  out  CNT_WIDTH  total accepted-or-dropped detections, saturating
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_overflow  out  1  sticky: at least one event dropped on a full FIFO

Behaviour:
- Reset (i_resetn=0, asynchronous): timestamp=0, FIFO empty, o_ts_valid=0, o_ts_data=0, o_event_count=0, o_fifo_level=0, o_overflow=0.
- Timestamp counter: increments by 1 on every edge with i_enable=1; holds when i_enable=0; wraps from 2^TS_WIDTH-1 to 0 with no flag.
- Event: i_pattern_found=1 and i_enable=1 at an edge.
  - The captured value is the timestamp before that edge's increment.
  - Back-to-back high cycles are separate events. No edge detection is applied.
- Event with i_enable=0: ignored. No count, no push.
- Push: an event pushes its timestamp when the FIFO is not full, or when the FIFO is full and a pop occurs on the same edge.
- Drop: an event when the FIFO is full with no pop on that edge is not pushed; o_overflow is set to 1 and stays 1 until i_clear or reset.
- o_event_count: +1 per event, whether pushed or dropped; saturates at 2^CNT_WIDTH-1 and never wraps.
- Pop: happens when o_ts_valid and i_ts_ready are both 1 at an edge. i_ts_ready with an empty FIFO has no effect.
- FWFT output:
  - o_ts_valid = (level != 0).
  - o_ts_data always shows the head entry; it shows 0 when empty.
- Latency: event at edge N gives o_ts_valid=1 and o_ts_data valid after edge N, when the FIFO was empty. Output is registered; there is no combinational path from i_pattern_found to the outputs.
- Simultaneous push and pop: level is unchanged.
  - When empty, a pop is impossible and the push is taken.
  - When full, both happen and nothing is dropped.
- o_fifo_level: range 0..FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.
- i_clear: synchronous and has priority over every event and handshake on the same edge.
  - Empties the FIFO.
  - Zeroes the timestamp, o_event_count and o_overflow.
  - An event coincident with clear is discarded.
- Reset mid-transfer: the FIFO contents are lost and o_ts_valid drops immediately, since reset is asynchronous. The consumer must not rely on the handshake completing across reset.
- No internal FSM beyond the FIFO pointer logic; all state is in counters and registers.

Decomposition:
- Package pattern_logger_pkg holds:
  - default constants TS_WIDTH_DEF=16, CNT_WIDTH_DEF=8, FIFO_DEPTH_DEF=4
  - a level-width function clog2
- Sub-module sync_fifo_fwft (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, level, clear).
  - It is the FIFO instantiated by pattern_event_logger.
  - It is reusable by other detector outputs.
- The top-level holds the timestamp counter, the event counter, overflow logic and the push/pop qualification.

Test Plan:
1. Reset, i_enable=1, single pulse at timestamp 10 -> o_ts_valid=1 one cycle later with o_ts_data=10, o_event_count=1, o_fifo_level=1. Then i_ts_ready=1 for one cycle -> o_ts_valid=0, o_fifo_level=0.
2. Detector-driven stream 1,0,1,0,0,1,0,1,0,0,1 with i_ts_ready=0 -> 2 entries, the second timestamp exactly 5 greater than the first (overlapping match), o_event_count=2, o_overflow=0.
3. i_ts_ready=0, 6 pulses with FIFO_DEPTH=4 -> o_fifo_level=4, o_event_count=6, o_overflow=1. Pop order returns the first 4 timestamps ascending.
4. FIFO full, pulse and pop on the same edge -> o_fifo_level stays 4, no drop, o_overflow unchanged. The newest timestamp appears as the fourth item after the pop.
5. CNT_WIDTH=3, 9 pulses with i_ts_ready=1 -> o_event_count saturates at 7. Then i_clear coincident with a pulse -> count=0, FIFO empty, o_overflow=0, pulse discarded.
6. i_enable=0 for 5 cycles with pulses -> no pushes, timestamp frozen. i_resetn pulled low while o_ts_valid=1 -> all outputs 0 asynchronously, before the next edge.
